hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core. Companion to the forwarding unit: it handles the hazards that forwarding cannot resolve.
- Cases handled: load-use stalls, taken-branch flushes, and multi-cycle mul/div occupancy of EX.
- Drives the PC / IF/ID / ID/EX write enables, flushes and EX/MEM bubble insertion. Keeps a saturating stall-cycle performance counter.

Parameters:
- MULDIV_LATENCY, 4, EX-stage occupancy in cycles of a mul/div op; legal range 1..2**CNT_W.
- CNT_W, 4, width of the mul/div countdown counter.
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs1  in  5  IF/ID.RegisterRs1.
- id_rs2  in  5  IF/ID.RegisterRs2.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  ID/EX.RegisterRd.
- ex_memRead  in  1  ID/EX.MemRead (load in EX).
- ex_muldiv  in  1  ID/EX instruction is mul/div; held high while that instruction sits in EX.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- idex_write  out  1  ID/EX register enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_flush  out  1  load bubble (control zeros) into ID/EX.
- exmem_bubble  out  1  load bubble into EX/MEM.
- muldiv_busy  out  1  high while in S_MULDIV.
- muldiv_done  out  1  one-cycle pulse: mul/div result valid in EX this cycle.
- stall_cycles  out  PERF_W  count of cycles with pc_write=0; saturates at all-ones.

Behaviour:
- Reset (async, any time, including mid-mul/div):
  - state=S_RUN, cnt=0, stall_cycles=0.
  - While reset is high, all outputs are 0, including pc_write, ifid_write and idex_write.
  - No muldiv_done pulse is emitted for an aborted op.
- States: S_RUN, S_MULDIV. Control outputs are combinational from state, cnt and inputs, so they are valid in the same cycle. State, cnt and stall_cycles are registered.
- Defaults: pc_write=ifid_write=idex_write=1; all flushes/bubbles/busy/done=0.
- load_use = ex_memRead & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- S_RUN, evaluated in priority order:
  1. ex_muldiv & MULDIV_LATENCY>1:
     - Outputs: pc_write=ifid_write=idex_write=0, exmem_bubble=1.
     - Next: S_MULDIV, cnt=MULDIV_LATENCY-2.
     - Branch and load_use are ignored this cycle.
  2. ex_muldiv & MULDIV_LATENCY==1:
     - muldiv_done=1, no stall, stay S_RUN.
     - Then evaluate items 3 and 4.
  3. ex_branch_taken:
     - Outputs: ifid_flush=1, idex_flush=1, pc_write=1.
     - load_use is suppressed because the ID instruction is squashed.
  4. load_use:
     - Outputs: pc_write=0, ifid_write=0, idex_flush=1.
     - Exactly one stall cycle; no state change.
- S_MULDIV:
  - cnt!=0: pc_write=ifid_write=idex_write=0, exmem_bubble=1, muldiv_busy=1, cnt decrements.
  - cnt==0:
    - Outputs: muldiv_busy=1, muldiv_done=1; write enables released (=1), no bubble.
    - Next: S_RUN.
    - Inputs ex_branch_taken and load_use are ignored in this cycle; the next instruction is evaluated in S_RUN.
  - ex_muldiv is don't-care in S_MULDIV; a back-to-back mul/div is re-detected in S_RUN on the following cycle.
- Timing: a mul/div occupies EX for exactly MULDIV_LATENCY cycles and causes MULDIV_LATENCY-1 stall cycles.
- stall_cycles: +1 on each rising edge where pc_write==0 and reset==0; holds at 2**PERF_W-1.
- Write-enable-low and flush on the same register never coexist: ifid_flush=1 implies ifid_write=1, and idex_flush=1 implies idex_write=1.

Test Plan:
- Load-use rs1: ex_memRead=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_cycles 0->1.
- x0 and unused operand: ex_rd=0 with id_rs1=0, then id_rs2==ex_rd=7 with id_uses_rs2=0 -> no stall in either case.
- Branch plus load-use in the same cycle: ex_branch_taken=1 and load_use true -> ifid_flush=1, idex_flush=1, pc_write=1; no stall.
- Mul/div with MULDIV_LATENCY=4: ex_muldiv=1 at cycle 0 -> stall and exmem_bubble asserted cycles 0-2; muldiv_done=1 and stalls released at cycle 3; stall_cycles=3.
- Back-to-back mul/div: second ex_muldiv seen at cycle 4 -> new stall window cycles 4-6, done at 7; stall_cycles=6.
- Reset at cycle 1 of a mul/div -> outputs 0 immediately, no muldiv_done pulse. After release: S_RUN, stall_cycles=0, pc_write=1.
- Saturation with PERF_W=4: hold load_use for 20 cycles -> stall_cycles stops at 15.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing: load-use stalls, branch flushes, mul/div EX occupancy.
// Also keeps a saturating count of cycles in which the PC was held.
module hazard_stall_controller #(
    parameter int MULDIV_LATENCY = 4,
    parameter int CNT_W          = 4,
    parameter int PERF_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [4:0]        ex_rd,
    input  logic              ex_memRead,
    input  logic              ex_muldiv,
    input  logic              ex_branch_taken,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_write,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_bubble,
    output logic              muldiv_busy,
    output logic              muldiv_done,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic {
        S_RUN,
        S_MULDIV
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULDIV_LATENCY - 2);
    localparam bit MULTI = (MULDIV_LATENCY > 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PERF_W-1:0]  stall_q, stall_d;

    logic load_use;
    logic pc_w, ifid_w, idex_w;
    logic ifid_f, idex_f, bub, busy, done;

    assign load_use = ex_memRead && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_w    = 1'b1;
        ifid_w  = 1'b1;
        idex_w  = 1'b1;
        ifid_f  = 1'b0;
        idex_f  = 1'b0;
        bub     = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (ex_muldiv && MULTI) begin
                    pc_w    = 1'b0;
                    ifid_w  = 1'b0;
                    idex_w  = 1'b0;
                    bub     = 1'b1;
                    state_d = S_MULDIV;
                    cnt_d   = CNT_INIT;
                end else begin
                    done = ex_muldiv;
                    // A taken branch squashes the ID instruction, so its
                    // load-use dependency no longer matters.
                    if (ex_branch_taken) begin
                        ifid_f = 1'b1;
                        idex_f = 1'b1;
                    end else if (load_use) begin
                        pc_w   = 1'b0;
                        ifid_w = 1'b0;
                        idex_f = 1'b1;
                    end
                end
            end
            S_MULDIV: begin
                busy = 1'b1;
                if (cnt_q != '0) begin
                    pc_w   = 1'b0;
                    ifid_w = 1'b0;
                    idex_w = 1'b0;
                    bub    = 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                end else begin
                    done    = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_w && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    // Everything is forced low while reset is asserted, enables included.
    assign pc_write     = pc_w   && !reset;
    assign ifid_write   = ifid_w && !reset;
    assign idex_write   = idex_w && !reset;
    assign ifid_flush   = ifid_f && !reset;
    assign idex_flush   = idex_f && !reset;
    assign exmem_bubble = bub    && !reset;
    assign muldiv_busy  = busy   && !reset;
    assign muldiv_done  = done   && !reset;
    assign stall_cycles = reset ? '0 : stall_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed plus random stimulus for hazard_stall_controller, checked against
// a cycle-position model of the pipeline hazard rules.
module tb_hazard_stall_controller;

    localparam int LAT    = 4;
    localparam int PERF_W = 4;
    localparam int SATMAX = (1 << PERF_W) - 1;

    logic              clk;
    logic              reset;
    logic [4:0]        id_rs1, id_rs2, ex_rd;
    logic              id_uses_rs1, id_uses_rs2;
    logic              ex_memRead, ex_muldiv, ex_branch_taken;
    logic              pc_write, ifid_write, idex_write;
    logic              ifid_flush, idex_flush, exmem_bubble;
    logic              muldiv_busy, muldiv_done;
    logic [PERF_W-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    // Model: position of the in-flight mul/div within its EX occupancy.
    bit m_active;
    int m_pos;
    int m_stalls;

    hazard_stall_controller #(
        .MULDIV_LATENCY(LAT),
        .CNT_W(4),
        .PERF_W(PERF_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd),
        .ex_memRead(ex_memRead),
        .ex_muldiv(ex_muldiv),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write),
        .ifid_write(ifid_write),
        .idex_write(idex_write),
        .ifid_flush(ifid_flush),
        .idex_flush(idex_flush),
        .exmem_bubble(exmem_bubble),
        .muldiv_busy(muldiv_busy),
        .muldiv_done(muldiv_done),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dut_vec();
        return {pc_write, ifid_write, idex_write, ifid_flush,
                idex_flush, exmem_bubble, muldiv_busy, muldiv_done};
    endfunction

    // Expected {pc_w, ifid_w, idex_w, ifid_f, idex_f, bubble, busy, done}.
    function automatic logic [7:0] model_vec();
        logic lu;
        logic [7:0] v;
        lu = ex_memRead && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) ||
              (id_uses_rs2 && id_rs2 == ex_rd));
        if (reset) return 8'b0;
        if (m_active) begin
            if (m_pos < LAT - 1) return 8'b000_00_1_1_0;
            return 8'b111_00_0_1_1;
        end
        if (ex_muldiv && LAT > 1) return 8'b000_00_1_0_0;
        v = 8'b111_00_0_0_0;
        v[0] = ex_muldiv;
        if (ex_branch_taken) begin
            v[4] = 1'b1;
            v[3] = 1'b1;
        end else if (lu) begin
            v[7] = 1'b0;
            v[6] = 1'b0;
            v[3] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_edge(input logic [7:0] v);
        if (reset) begin
            m_active = 0;
            m_pos    = 0;
            m_stalls = 0;
        end else begin
            if (!v[7] && m_stalls < SATMAX) m_stalls++;
            if (m_active) begin
                if (m_pos < LAT - 1) m_pos++;
                else m_active = 0;
            end else if (ex_muldiv && LAT > 1) begin
                m_active = 1;
                m_pos    = 1;
            end
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2,
                          input logic [4:0] rd, input logic mr,
                          input logic md, input logic br);
        id_rs1 = rs1;
        id_rs2 = rs2;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        ex_rd = rd;
        ex_memRead = mr;
        ex_muldiv = md;
        ex_branch_taken = br;
    endtask

    // Inputs are set just after a rising edge; check at the falling edge.
    task automatic run_cycle(input string tag);
        logic [7:0] e;
        @(negedge clk);
        e = model_vec();
        chk({tag, ".ctl"}, 32'(dut_vec()), 32'(e));
        chk({tag, ".stall"}, 32'(stall_cycles), 32'(m_stalls));
        @(posedge clk);
        model_edge(e);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        model_edge(8'b0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        m_active = 0;
        m_pos = 0;
        m_stalls = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst.ctl", 32'(dut_vec()), 32'h0);
        chk("rst.stall", 32'(stall_cycles), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        set_in(5, 0, 1, 0, 5, 1, 0, 0);
        run_cycle("lu_rs1");
        chk("lu_rs1.cnt", 32'(stall_cycles), 32'd1);

        set_in(0, 0, 1, 0, 0, 1, 0, 0);
        run_cycle("x0");
        set_in(3, 7, 1, 0, 7, 1, 0, 0);
        run_cycle("rs2_unused");
        set_in(3, 7, 1, 1, 7, 1, 0, 0);
        run_cycle("lu_rs2");
        set_in(7, 7, 1, 1, 7, 1, 0, 1);
        run_cycle("br_lu");

        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) run_cycle("md1");
        chk("md1.cnt", 32'(stall_cycles), 32'd3);
        for (int i = 0; i < 4; i++) run_cycle("md2");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle("md_end");
        chk("md2.cnt", 32'(stall_cycles), 32'd6);

        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        run_cycle("mdr0");
        #2;
        reset = 1'b1;
        #1;
        chk("mdr.ctl", 32'(dut_vec()), 32'h0);
        chk("mdr.stall", 32'(stall_cycles), 32'h0);
        @(posedge clk);
        model_edge(8'b0);
        #1;
        chk("mdr.hold", 32'(dut_vec()), 32'h0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        run_cycle("mdr_after");
        chk("mdr.pc", 32'(pc_write), 32'd1);

        set_in(9, 0, 1, 0, 9, 1, 0, 0);
        for (int i = 0; i < 20; i++) run_cycle("sat");
        chk("sat.cnt", 32'(stall_cycles), 32'd15);

        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                   1'($urandom), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 3) == 0));
            run_cycle("rnd");
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
